// File: rtl/loader_pkg.sv
// Shared types and constants for the byte-stream program loader.
package loader_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_COUNT,
      ST_ADDR,
      ST_DATA,
      ST_WRITE,
      ST_CSUM,
      ST_RELEASE,
      ST_RUN,
      ST_ERROR
   } loader_state_t;

   localparam logic [7:0] SYNC_BYTE   = 8'hA5;
   localparam int         MAX_REC_DEF = 16;

   // Record counter must hold MAX_REC itself, not just MAX_REC-1.
   function automatic int cnt_width(input int max_rec);
      return $clog2(max_rec + 1);
   endfunction

   localparam int CNT_W_DEF = cnt_width(MAX_REC_DEF);

endpackage

// File: rtl/loader_csum.sv
// Modulo-2^DATA_W frame checksum accumulator; clear and add in the same cycle
// loads the new byte so the COUNT byte can start a fresh sum.
module loader_csum
   import loader_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clr,
   input  logic              add_en,
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] sum
);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sum <= '0;
      end else if (clr) begin
         sum <= add_en ? din : '0;
      end else if (add_en) begin
         sum <= sum + din;
      end
   end

endmodule

// File: rtl/program_loader.sv
// Framed program loader: SYNC, COUNT, COUNT x {ADDR, DATA}, CSUM. Drives the RAM
// load port and holds the CPU in reset until a frame checksum verifies.
module program_loader
   import loader_pkg::*;
#(
   parameter int ADDR_W  = 4,
   parameter int DATA_W  = 8,
   parameter int MAX_REC = MAX_REC_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              rx_valid,
   input  logic [DATA_W-1:0] rx_data,
   output logic              rx_ready,
   output logic              input_mode,
   output logic [ADDR_W-1:0] input_address,
   output logic [DATA_W-1:0] input_program,
   output logic              prog_we,
   output logic              cpu_reset_n,
   output logic              done,
   output logic              err
);

   localparam int                CNT_W   = cnt_width(MAX_REC);
   localparam logic [DATA_W-1:0] SYNC    = DATA_W'(SYNC_BYTE);
   localparam logic [DATA_W-1:0] MAX_B   = DATA_W'(MAX_REC);
   localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

   loader_state_t     state;
   logic [CNT_W-1:0]  cnt;
   logic [DATA_W-1:0] csum;
   logic              accept;
   logic              is_sync;
   logic              count_ok;
   logic              addr_ok;
   logic              csum_clr;
   logic              csum_add;

   assign rx_ready = (state != ST_WRITE) && (state != ST_RELEASE);
   assign accept   = rx_valid && rx_ready;
   assign is_sync  = (rx_data == SYNC);
   assign count_ok = (rx_data != '0) && (rx_data <= MAX_B);
   assign addr_ok  = (rx_data[DATA_W-1:ADDR_W] == '0);

   always_comb begin
      csum_clr = 1'b0;
      csum_add = 1'b0;
      if (accept) begin
         case (state)
            ST_COUNT: begin
               csum_clr = 1'b1;
               csum_add = count_ok;
            end
            ST_ADDR: csum_add = addr_ok;
            ST_DATA: csum_add = 1'b1;
            default: ;
         endcase
      end
   end

   loader_csum #(.DATA_W(DATA_W)) u_csum (
      .clk    (clk),
      .reset  (reset),
      .clr    (csum_clr),
      .add_en (csum_add),
      .din    (rx_data),
      .sum    (csum)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state         <= ST_IDLE;
         cnt           <= '0;
         input_mode    <= 1'b1;
         cpu_reset_n   <= 1'b0;
         input_address <= '0;
         input_program <= '0;
         prog_we       <= 1'b0;
         done          <= 1'b0;
         err           <= 1'b0;
      end else begin
         prog_we <= 1'b0;
         case (state)
            ST_IDLE: if (accept && is_sync) state <= ST_COUNT;
            ST_COUNT: if (accept) begin
               if (count_ok) begin
                  cnt   <= CNT_W'(rx_data);
                  state <= ST_ADDR;
               end else begin
                  err   <= 1'b1;
                  state <= ST_ERROR;
               end
            end
            ST_ADDR: if (accept) begin
               if (addr_ok) begin
                  input_address <= rx_data[ADDR_W-1:0];
                  state         <= ST_DATA;
               end else begin
                  err   <= 1'b1;
                  state <= ST_ERROR;
               end
            end
            ST_DATA: if (accept) begin
               input_program <= rx_data;
               prog_we       <= 1'b1;
               state         <= ST_WRITE;
            end
            ST_WRITE: begin
               cnt   <= cnt - CNT_ONE;
               state <= (cnt == CNT_ONE) ? ST_CSUM : ST_ADDR;
            end
            // Writes already issued stay in RAM on a bad checksum.
            ST_CSUM: if (accept) begin
               if (rx_data == csum) begin
                  input_mode <= 1'b0;
                  state      <= ST_RELEASE;
               end else begin
                  err   <= 1'b1;
                  state <= ST_ERROR;
               end
            end
            ST_RELEASE: begin
               cpu_reset_n <= 1'b1;
               done        <= 1'b1;
               state       <= ST_RUN;
            end
            ST_RUN: if (accept && is_sync) begin
               input_mode  <= 1'b1;
               cpu_reset_n <= 1'b0;
               done        <= 1'b0;
               state       <= ST_COUNT;
            end
            ST_ERROR: if (accept && is_sync) begin
               err   <= 1'b0;
               state <= ST_COUNT;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: good/bad frames, flow control, reload, mid-frame reset.
module tb_program_loader;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       rx_valid = 1'b0;
   logic [7:0] rx_data = 8'h00;
   logic       rx_ready, input_mode, prog_we, cpu_reset_n, done, err;
   logic [3:0] input_address;
   logic [7:0] input_program;

   int n_chk = 0;
   int n_fail = 0;
   logic [11:0] wq[$];
   logic [7:0]  frm[$];

   program_loader dut (
      .clk           (clk),
      .reset         (reset),
      .rx_valid      (rx_valid),
      .rx_data       (rx_data),
      .rx_ready      (rx_ready),
      .input_mode    (input_mode),
      .input_address (input_address),
      .input_program (input_program),
      .prog_we       (prog_we),
      .cpu_reset_n   (cpu_reset_n),
      .done          (done),
      .err           (err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (prog_we) wq.push_back({input_address, input_program});

   initial begin
      #200000;
      $display("FAIL watchdog expired got running expected finished");
      $fatal(1, "watchdog");
   end

   task automatic send(input logic [7:0] b, input int maxgap);
      int n;
      rx_valid = 1'b0;
      if (maxgap > 0) repeat ($urandom_range(0, maxgap)) begin
         rx_data = 8'($urandom);
         @(negedge clk);
      end
      rx_valid = 1'b1;
      rx_data  = b;
      n = 0;
      while (!rx_ready && n < 20) begin @(negedge clk); n++; end
      if (n >= 20) begin n_chk++; n_fail++; $display("FAIL send_timeout got rx_ready=%b expected 1", rx_ready); end
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic send_frame(input int maxgap);
      foreach (frm[i]) send(frm[i], maxgap);
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (2) @(negedge clk);
      n_chk++; if (input_mode !== 1'b1) begin n_fail++; $display("FAIL rst_mode got %b expected 1", input_mode); end
      n_chk++; if (cpu_reset_n !== 1'b0) begin n_fail++; $display("FAIL rst_cpu got %b expected 0", cpu_reset_n); end
      n_chk++; if ({prog_we, done, err} !== 3'b000) begin n_fail++; $display("FAIL rst_flags got %b expected 000", {prog_we, done, err}); end
      n_chk++; if ({input_address, input_program} !== 12'h000) begin n_fail++; $display("FAIL rst_addr_data got %h expected 000", {input_address, input_program}); end
      reset = 1'b1;
      @(negedge clk);
      n_chk++; if (rx_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready got %b expected 1", rx_ready); end
   endtask

   task automatic test_good_frame();
      logic [11:0] exp[$];
      exp = '{12'h909, 12'h079, 12'h150, 12'h240};
      wq.delete();
      frm = '{8'hA5, 8'h04, 8'h09, 8'h09, 8'h00, 8'h79, 8'h01, 8'h50, 8'h02, 8'h40, 8'h22};
      for (int i = 0; i < 11; i++) begin
         send(frm[i], 0);
         if (i == 3 || i == 5 || i == 7 || i == 9) begin
            n_chk++; if (prog_we !== 1'b1 || rx_ready !== 1'b0) begin n_fail++; $display("FAIL good_we%0d got we=%b rdy=%b expected we=1 rdy=0", i, prog_we, rx_ready); end
            n_chk++; if ({input_address, input_program} !== {4'(frm[i-1]), frm[i]}) begin n_fail++; $display("FAIL good_wr%0d got %h expected %h", i, {input_address, input_program}, {4'(frm[i-1]), frm[i]}); end
         end
      end
      n_chk++; if ({input_mode, cpu_reset_n, done, rx_ready} !== 4'b0000) begin n_fail++; $display("FAIL good_release got %b expected 0000", {input_mode, cpu_reset_n, done, rx_ready}); end
      @(negedge clk);
      n_chk++; if ({input_mode, cpu_reset_n, done, rx_ready, err} !== 5'b01110) begin n_fail++; $display("FAIL good_run got %b expected 01110", {input_mode, cpu_reset_n, done, rx_ready, err}); end
      n_chk++; if (wq.size() != 4) begin n_fail++; $display("FAIL good_nwr got %0d expected 4", wq.size()); end
      else foreach (exp[i]) begin
         n_chk++; if (wq[i] !== exp[i]) begin n_fail++; $display("FAIL good_q%0d got %h expected %h", i, wq[i], exp[i]); end
      end
   endtask

   task automatic test_bad_csum();
      wq.delete();
      frm = '{8'hA5, 8'h04, 8'h09, 8'h09, 8'h00, 8'h79, 8'h01, 8'h50, 8'h02, 8'h40, 8'h23};
      send_frame(0);
      @(negedge clk);
      n_chk++; if ({err, input_mode, cpu_reset_n, done} !== 4'b1100) begin n_fail++; $display("FAIL badcs_state got %b expected 1100", {err, input_mode, cpu_reset_n, done}); end
      n_chk++; if (wq.size() != 4) begin n_fail++; $display("FAIL badcs_nwr got %0d expected 4", wq.size()); end
      frm = '{8'hA5, 8'h04, 8'h09, 8'h09, 8'h00, 8'h79, 8'h01, 8'h50, 8'h02, 8'h40, 8'h22};
      send(8'hA5, 0);
      n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL badcs_clr got %b expected 0", err); end
      for (int i = 1; i < 11; i++) send(frm[i], 0);
      @(negedge clk);
      n_chk++; if ({done, cpu_reset_n, err} !== 3'b110) begin n_fail++; $display("FAIL badcs_reload got %b expected 110", {done, cpu_reset_n, err}); end
   endtask

   task automatic test_bad_fields();
      wq.delete();
      frm = '{8'hA5, 8'h00};
      send_frame(0);
      n_chk++; if ({err, input_mode, cpu_reset_n} !== 3'b110) begin n_fail++; $display("FAIL cnt0 got %b expected 110", {err, input_mode, cpu_reset_n}); end
      frm = '{8'hA5, 8'h11};
      send_frame(0);
      n_chk++; if (err !== 1'b1) begin n_fail++; $display("FAIL cnt17 got %b expected 1", err); end
      frm = '{8'hA5, 8'h10};
      send_frame(0);
      n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL cnt16_ok got %b expected 0", err); end
      frm = '{8'hA5, 8'h01, 8'h19};
      send_frame(0);
      @(negedge clk);
      n_chk++; if (err !== 1'b1) begin n_fail++; $display("FAIL addr19 got %b expected 1", err); end
      n_chk++; if (wq.size() != 0) begin n_fail++; $display("FAIL bad_nwr got %0d expected 0", wq.size()); end
   endtask

   task automatic test_random_valid();
      logic [11:0] exp[$];
      exp = '{12'h909, 12'h079, 12'h150, 12'h240};
      wq.delete();
      frm = '{8'hA5, 8'h04, 8'h09, 8'h09, 8'h00, 8'h79, 8'h01, 8'h50, 8'h02, 8'h40, 8'h22};
      send_frame(3);
      repeat (2) @(negedge clk);
      n_chk++; if ({done, cpu_reset_n, input_mode, err} !== 4'b1100) begin n_fail++; $display("FAIL rv_run got %b expected 1100", {done, cpu_reset_n, input_mode, err}); end
      n_chk++; if (wq.size() != 4) begin n_fail++; $display("FAIL rv_nwr got %0d expected 4", wq.size()); end
      else foreach (exp[i]) begin
         n_chk++; if (wq[i] !== exp[i]) begin n_fail++; $display("FAIL rv_q%0d got %h expected %h", i, wq[i], exp[i]); end
      end
   endtask

   task automatic test_run_reload();
      wq.delete();
      send(8'h33, 0);
      @(negedge clk);
      n_chk++; if ({done, cpu_reset_n, input_mode, rx_ready} !== 4'b1101) begin n_fail++; $display("FAIL run_ignore got %b expected 1101", {done, cpu_reset_n, input_mode, rx_ready}); end
      send(8'hA5, 0);
      n_chk++; if ({done, cpu_reset_n, input_mode} !== 3'b001) begin n_fail++; $display("FAIL reload_hold got %b expected 001", {done, cpu_reset_n, input_mode}); end
      frm = '{8'h01, 8'h05, 8'h7F, 8'h85};
      send_frame(0);
      n_chk++; if ({input_mode, cpu_reset_n} !== 2'b00) begin n_fail++; $display("FAIL reload_rel got %b expected 00", {input_mode, cpu_reset_n}); end
      @(negedge clk);
      n_chk++; if ({done, cpu_reset_n} !== 2'b11) begin n_fail++; $display("FAIL reload_run got %b expected 11", {done, cpu_reset_n}); end
      n_chk++; if (wq.size() != 1 || wq[0] !== 12'h57F) begin n_fail++; $display("FAIL reload_wr got n=%0d w=%h expected n=1 w=57f", wq.size(), wq.size() > 0 ? wq[0] : 12'h0); end
   endtask

   task automatic test_reset_midframe();
      logic [11:0] exp[$];
      exp = '{12'h909, 12'h079, 12'h150, 12'h240};
      wq.delete();
      frm = '{8'hA5, 8'h04, 8'h09, 8'h09, 8'h00, 8'h79};
      send_frame(0);
      @(negedge clk);
      n_chk++; if (wq.size() != 2) begin n_fail++; $display("FAIL mid_nwr got %0d expected 2", wq.size()); end
      #2 reset = 1'b0;
      #1;
      n_chk++; if ({input_mode, cpu_reset_n, prog_we, done, err} !== 5'b10000) begin n_fail++; $display("FAIL mid_rst_flags got %b expected 10000", {input_mode, cpu_reset_n, prog_we, done, err}); end
      n_chk++; if ({input_address, input_program} !== 12'h000) begin n_fail++; $display("FAIL mid_rst_addr_data got %h expected 000", {input_address, input_program}); end
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      wq.delete();
      frm = '{8'hA5, 8'h04, 8'h09, 8'h09, 8'h00, 8'h79, 8'h01, 8'h50, 8'h02, 8'h40, 8'h22};
      send_frame(0);
      @(negedge clk);
      n_chk++; if ({done, cpu_reset_n, input_mode} !== 3'b110) begin n_fail++; $display("FAIL mid_run got %b expected 110", {done, cpu_reset_n, input_mode}); end
      n_chk++; if (wq.size() != 4) begin n_fail++; $display("FAIL mid_nwr2 got %0d expected 4", wq.size()); end
      else foreach (exp[i]) begin
         n_chk++; if (wq[i] !== exp[i]) begin n_fail++; $display("FAIL mid_q%0d got %h expected %h", i, wq[i], exp[i]); end
      end
   endtask

   initial begin
      test_reset();
      test_good_frame();
      test_bad_csum();
      test_bad_fields();
      test_random_valid();
      test_run_reload();
      test_reset_midframe();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
